// File: rtl/paddle_controller_pkg.sv
// Shared types and constants for the paddle position controller.
// Default geometry matches a 640-wide screen with a 64-pixel bar sprite.
package paddle_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        STEP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } dir_t;

    localparam int SCREEN_W_DEF     = 640;
    localparam int PADDLE_W_DEF     = 64;
    localparam int PADDLE_Y_DEF     = 440;
    localparam int MIN_SPEED_DEF    = 2;
    localparam int MAX_SPEED_DEF    = 8;
    localparam int ACCEL_FRAMES_DEF = 4;

    localparam int MAX_X  = SCREEN_W_DEF - PADDLE_W_DEF;
    localparam int CENTER = MAX_X / 2;

    // Saturate a signed candidate position into 0..max_x.
    function automatic logic [9:0] clamp_x(input logic signed [10:0] nx,
                                           input logic [9:0]        max_x);
        if (nx[10]) begin
            return '0;
        end
        if (nx > $signed({1'b0, max_x})) begin
            return max_x;
        end
        return nx[9:0];
    endfunction

endpackage

// File: rtl/paddle_controller_if.sv
// Button/frame inputs and paddle position outputs of one paddle controller.
// master is the controller side, slave is the pins/sprite side.
interface paddle_controller_if;

    logic       vsync;
    logic       btn_left;
    logic       btn_right;
    logic       enable;
    logic       center;
    logic [9:0] paddle_x;
    logic [9:0] paddle_y;
    logic [3:0] speed;
    logic       at_left;
    logic       at_right;
    logic       frame_done;

    modport master (
        input  vsync, btn_left, btn_right, enable, center,
        output paddle_x, paddle_y, speed, at_left, at_right, frame_done
    );

    modport slave (
        output vsync, btn_left, btn_right, enable, center,
        input  paddle_x, paddle_y, speed, at_left, at_right, frame_done
    );

endinterface

// File: rtl/paddle_controller_sync.sv
// Two-flop synchronizer for an asynchronous pin, with an optional registered
// one-cycle pulse on the synchronized falling edge.
module input_sync #(
    parameter bit EDGE_EN = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
        end
    end

    assign dout = sync_reg;

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_reg;
            logic fall_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    prev_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end else begin
                    prev_reg <= sync_reg;
                    fall_reg <= prev_reg & ~sync_reg;
                end
            end

            assign fall = fall_reg;
        end else begin : g_no_edge
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/paddle_controller.sv
// Per-frame paddle position controller: synchronizes vsync and buttons, ramps
// speed while a button is held and commits a clamped position once per frame.
module paddle_controller
    import paddle_controller_pkg::*;
#(
    parameter int SCREEN_W     = SCREEN_W_DEF,
    parameter int PADDLE_W     = PADDLE_W_DEF,
    parameter int PADDLE_Y     = PADDLE_Y_DEF,
    parameter int MIN_SPEED    = MIN_SPEED_DEF,
    parameter int MAX_SPEED    = MAX_SPEED_DEF,
    parameter int ACCEL_FRAMES = ACCEL_FRAMES_DEF
) (
    input logic                 clk,
    input logic                 reset,
    paddle_controller_if.master pif
);

    localparam logic [9:0] MAX_X_C      = 10'(SCREEN_W - PADDLE_W);
    localparam logic [9:0] CENTER_C     = 10'((SCREEN_W - PADDLE_W) / 2);
    localparam logic [9:0] PADDLE_Y_C   = 10'(PADDLE_Y);
    localparam logic [3:0] MIN_SPEED_C  = 4'(MIN_SPEED);
    localparam logic [3:0] MAX_SPEED_C  = 4'(MAX_SPEED);
    localparam logic [7:0] ACCEL_LAST_C = 8'(ACCEL_FRAMES - 1);

    logic       vsync_tick;
    logic       vsync_level_unused;
    logic [1:0] btn_raw;
    logic [1:0] btn_sync;
    logic [1:0] btn_fall_unused;

    // Bit 0 is the left button, bit 1 the right button.
    assign btn_raw = {pif.btn_right, pif.btn_left};

    input_sync #(.EDGE_EN(1'b1)) u_vsync_sync (
        .clk  (clk),
        .reset(reset),
        .din  (pif.vsync),
        .dout (vsync_level_unused),
        .fall (vsync_tick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn_sync
            input_sync #(.EDGE_EN(1'b0)) u_btn_sync (
                .clk  (clk),
                .reset(reset),
                .din  (btn_raw[gi]),
                .dout (btn_sync[gi]),
                .fall (btn_fall_unused[gi])
            );
        end
    endgenerate

    state_t state_reg, state_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Ticks arriving outside IDLE are dropped: one update per frame.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (vsync_tick) state_next = EVAL;
            EVAL:    state_next = STEP;
            STEP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic frame_done_c;

    always_comb begin
        frame_done_c = 1'b0;
        if (state_reg == STEP) begin
            frame_done_c = 1'b1;
        end
    end

    logic [3:0] speed_reg, speed_next;
    logic [7:0] count_reg, count_next;
    dir_t       dir_reg, dir_next;
    logic       center_reg, center_next;
    logic [9:0] x_reg, x_next;
    logic       at_left_reg, at_left_next;
    logic       at_right_reg, at_right_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speed_reg    <= '0;
            count_reg    <= '0;
            dir_reg      <= NONE;
            center_reg   <= 1'b0;
            x_reg        <= CENTER_C;
            at_left_reg  <= 1'b0;
            at_right_reg <= 1'b0;
        end else begin
            speed_reg    <= speed_next;
            count_reg    <= count_next;
            dir_reg      <= dir_next;
            center_reg   <= center_next;
            x_reg        <= x_next;
            at_left_reg  <= at_left_next;
            at_right_reg <= at_right_next;
        end
    end

    logic signed [10:0] step_nx;

    always_comb begin
        step_nx = $signed({1'b0, x_reg});
        case (dir_reg)
            LEFT:    step_nx = $signed({1'b0, x_reg}) - $signed({7'd0, speed_reg});
            RIGHT:   step_nx = $signed({1'b0, x_reg}) + $signed({7'd0, speed_reg});
            default: step_nx = $signed({1'b0, x_reg});
        endcase
    end

    dir_t want_dir;

    always_comb begin
        speed_next    = speed_reg;
        count_next    = count_reg;
        dir_next      = dir_reg;
        center_next   = center_reg;
        x_next        = x_reg;
        at_left_next  = at_left_reg;
        at_right_next = at_right_reg;
        want_dir      = NONE;

        if (state_reg == EVAL) begin
            center_next = pif.center;
            // center and !enable both collapse to "no direction wanted".
            if (pif.enable && !pif.center && (btn_sync[0] ^ btn_sync[1])) begin
                want_dir = btn_sync[0] ? LEFT : RIGHT;
            end

            if (want_dir == NONE) begin
                speed_next = '0;
                count_next = '0;
                dir_next   = NONE;
            end else if (dir_reg != want_dir) begin
                dir_next   = want_dir;
                speed_next = MIN_SPEED_C;
                count_next = '0;
            end else if (count_reg == ACCEL_LAST_C) begin
                count_next = '0;
                speed_next = (speed_reg >= MAX_SPEED_C) ? MAX_SPEED_C : speed_reg + 4'd1;
            end else begin
                count_next = count_reg + 8'd1;
            end
        end

        if (state_reg == STEP) begin
            x_next        = center_reg ? CENTER_C : clamp_x(step_nx, MAX_X_C);
            at_left_next  = (x_next == 10'd0);
            at_right_next = (x_next == MAX_X_C);
        end
    end

    assign pif.paddle_x   = x_reg;
    assign pif.paddle_y   = PADDLE_Y_C;
    assign pif.speed      = speed_reg;
    assign pif.at_left    = at_left_reg;
    assign pif.at_right   = at_right_reg;
    assign pif.frame_done = frame_done_c;

endmodule

// File: tb/tb_paddle_controller.sv
// Scoreboard bench for paddle_controller: each frame pushes its expected commit,
// a monitor pops and compares on every frame_done pulse.
module tb_paddle_controller;
    import paddle_controller_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    paddle_controller_if pif ();

    paddle_controller #(
        .SCREEN_W    (640),
        .PADDLE_W    (64),
        .PADDLE_Y    (440),
        .MIN_SPEED   (2),
        .MAX_SPEED   (8),
        .ACCEL_FRAMES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .pif  (pif)
    );

    typedef struct {
        int speed;
        int x;
        int al;
        int ar;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Frame-level behavioural model: dir 0=none, 1=left, 2=right.
    int m_x     = CENTER;
    int m_speed = 0;
    int m_count = 0;
    int m_dir   = 0;

    task automatic check(input string name, input int act, input int req);
        tests_run++;
        if (act != req) begin
            tests_failed++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end else begin
            $display("PASS %s: %0d", name, act);
        end
    endtask

    task automatic model_reset();
        m_x     = CENTER;
        m_speed = 0;
        m_count = 0;
        m_dir   = 0;
    endtask

    task automatic model_frame(input bit l, input bit r, input bit en, input bit ctr);
        exp_t e;
        int   nd;
        if (ctr) begin
            m_speed = 0; m_count = 0; m_dir = 0; m_x = CENTER;
        end else if (!en || (l == r)) begin
            m_speed = 0; m_count = 0; m_dir = 0;
        end else begin
            nd = l ? 1 : 2;
            if (m_dir != nd) begin
                m_dir = nd; m_speed = 2; m_count = 0;
            end else if (m_count == 3) begin
                m_count = 0;
                m_speed = (m_speed + 1 > 8) ? 8 : m_speed + 1;
            end else begin
                m_count++;
            end
            m_x = (m_dir == 1) ? m_x - m_speed : m_x + m_speed;
            if (m_x < 0) m_x = 0;
            if (m_x > MAX_X) m_x = MAX_X;
        end
        e.speed = m_speed;
        e.x     = m_x;
        e.al    = (m_x == 0) ? 1 : 0;
        e.ar    = (m_x == MAX_X) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    // One frame: set inputs, pulse vsync low, report clocks until frame_done.
    task automatic frame(input bit l, input bit r, input bit en, input bit ctr, output int lat);
        pif.btn_left  = l;
        pif.btn_right = r;
        pif.enable    = en;
        pif.center    = ctr;
        model_frame(l, r, en, ctr);
        pif.vsync = 1'b1;
        repeat (3) @(negedge clk);
        pif.vsync = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (pif.frame_done === 1'b1 && lat < 0) lat = k;
        end
    endtask

    initial begin : monitor
        exp_t e;
        int   s;
        forever begin
            @(negedge clk);
            if (pif.frame_done === 1'b1) begin
                s = int'(pif.speed);
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL sb_unexpected: actual=frame_done required=no_pending_frame");
                end else begin
                    e = exp_q.pop_front();
                    check("sb_speed", s, e.speed);
                    check("sb_x", int'(pif.paddle_x), e.x);
                    check("sb_at_left", int'(pif.at_left), e.al);
                    check("sb_at_right", int'(pif.at_right), e.ar);
                    check("sb_pulse_width", int'(pif.frame_done), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        int lat;
        int fd_cnt;
        int sp2 [10];
        sp2 = '{2, 2, 2, 2, 3, 3, 3, 3, 4, 4};

        pif.vsync     = 1'b1;
        pif.btn_left  = 1'b0;
        pif.btn_right = 1'b0;
        pif.enable    = 1'b1;
        pif.center    = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_paddle_x", int'(pif.paddle_x), 288);
        check("reset_speed", int'(pif.speed), 0);
        check("reset_at_left", int'(pif.at_left), 0);
        check("reset_at_right", int'(pif.at_right), 0);
        check("reset_frame_done", int'(pif.frame_done), 0);
        check("reset_paddle_y", int'(pif.paddle_y), 440);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Idle frames and commit latency from the vsync pin edge.
        for (int i = 0; i < 3; i++) begin
            frame(1'b0, 1'b0, 1'b1, 1'b0, lat);
            check($sformatf("t1_latency_%0d", i), lat, 5);
        end
        check("t1_x", int'(pif.paddle_x), 288);
        check("t1_speed", int'(pif.speed), 0);

        // Hold right: speed ramp.
        for (int i = 0; i < 10; i++) begin
            frame(1'b0, 1'b1, 1'b1, 1'b0, lat);
            check($sformatf("t2_speed_%0d", i), int'(pif.speed), sp2[i]);
        end
        check("t2_x", int'(pif.paddle_x), 316);
        check("t2_paddle_y", int'(pif.paddle_y), 440);

        // Left wall: 46 held frames reach x=4, the 47th clamps to 0.
        frame(1'b0, 1'b0, 1'b1, 1'b1, lat);
        for (int i = 0; i < 46; i++) frame(1'b1, 1'b0, 1'b1, 1'b0, lat);
        check("t3_x_before_wall", int'(pif.paddle_x), 4);
        frame(1'b1, 1'b0, 1'b1, 1'b0, lat);
        check("t3_x_wall", int'(pif.paddle_x), 0);
        check("t3_at_left", int'(pif.at_left), 1);
        frame(1'b1, 1'b0, 1'b1, 1'b0, lat);
        check("t3_speed_pinned", int'(pif.speed), 8);
        check("t3_x_pinned", int'(pif.paddle_x), 0);

        // Right wall: 572 after 46 frames, clamp to 576 on the 47th.
        frame(1'b0, 1'b0, 1'b1, 1'b1, lat);
        check("t3_center", int'(pif.paddle_x), 288);
        for (int i = 0; i < 46; i++) frame(1'b0, 1'b1, 1'b1, 1'b0, lat);
        check("t3_x_before_rwall", int'(pif.paddle_x), 572);
        check("t3_at_right_clear", int'(pif.at_right), 0);
        frame(1'b0, 1'b1, 1'b1, 1'b0, lat);
        check("t3_x_rwall", int'(pif.paddle_x), 576);
        check("t3_at_right", int'(pif.at_right), 1);

        // Reversal at speed 5.
        frame(1'b0, 1'b0, 1'b1, 1'b1, lat);
        for (int i = 0; i < 13; i++) frame(1'b0, 1'b1, 1'b1, 1'b0, lat);
        check("t4_speed5", int'(pif.speed), 5);
        check("t4_x", int'(pif.paddle_x), 329);
        frame(1'b1, 1'b0, 1'b1, 1'b0, lat);
        check("t4_rev_speed", int'(pif.speed), 2);
        check("t4_rev_x", int'(pif.paddle_x), 327);

        // Both buttons, enable low, centre over a held button.
        frame(1'b1, 1'b0, 1'b1, 1'b0, lat);
        frame(1'b1, 1'b1, 1'b1, 1'b0, lat);
        check("t5_both_speed", int'(pif.speed), 0);
        check("t5_both_x", int'(pif.paddle_x), 325);
        frame(1'b1, 1'b0, 1'b1, 1'b0, lat);
        frame(1'b1, 1'b0, 1'b0, 1'b0, lat);
        check("t5_disabled_speed", int'(pif.speed), 0);
        check("t5_disabled_x", int'(pif.paddle_x), 323);
        frame(1'b0, 1'b1, 1'b1, 1'b1, lat);
        check("t5_center_x", int'(pif.paddle_x), 288);
        check("t5_center_speed", int'(pif.speed), 0);

        // Reset pulse while the frame update is in EVAL.
        frame(1'b0, 1'b1, 1'b1, 1'b0, lat);
        frame(1'b0, 1'b1, 1'b1, 1'b0, lat);
        check("t6_pre_x", int'(pif.paddle_x), 292);
        pif.btn_right = 1'b0;
        pif.vsync     = 1'b1;
        repeat (3) @(negedge clk);
        pif.vsync = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        fd_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (pif.frame_done === 1'b1) fd_cnt++;
        end
        check("t6_abort_no_frame_done", fd_cnt, 0);
        check("t6_abort_x", int'(pif.paddle_x), 288);
        check("t6_abort_speed", int'(pif.speed), 0);

        // Second vsync edge inside the EVAL/STEP window is ignored.
        pif.btn_right = 1'b1;
        model_frame(1'b0, 1'b1, 1'b1, 1'b0);
        pif.vsync = 1'b1;
        repeat (3) @(negedge clk);
        pif.vsync = 1'b0;
        @(negedge clk);
        pif.vsync = 1'b1;
        @(negedge clk);
        pif.vsync = 1'b0;
        fd_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (pif.frame_done === 1'b1) fd_cnt++;
        end
        check("t6_one_update", fd_cnt, 1);
        check("t6_double_x", int'(pif.paddle_x), 290);
        frame(1'b0, 1'b1, 1'b1, 1'b0, lat);
        check("t6_next_x", int'(pif.paddle_x), 292);

        repeat (5) @(negedge clk);
        check("sb_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
